// File: rtl/maxnet_param.sv
// maxnet_param: parametrised winner-take-all (MaxNet) engine.
// Latches N unsigned W-bit activations on start. It then applies one
// lateral-inhibition update per clock until a single non-zero activation
// remains, all activations are zero, or MAX_ITER updates have been done.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset (aborts any run)
//   start      begin a run; only honoured in IDLE
//   in_data    N*W activations, channel i = in_data[i*W +: W]
//   busy       high from the accepting edge until the cycle after DONE
//   done       one-cycle pulse while in DONE
//   result     original input value of the winner (0 if none)
//   winner_idx winning channel (0 if none)
//   valid      unique winner found
//   timeout    MAX_ITER reached without convergence
//   iter_count number of updates performed in the last run
module maxnet_param #(
  parameter int unsigned N         = 4,
  parameter int unsigned W         = 32,
  parameter int unsigned EPS_SHIFT = 3,
  parameter int unsigned MAX_ITER  = 255,
  parameter int unsigned IW        = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [N*W-1:0]       in_data,
  output logic                 busy,
  output logic                 done,
  output logic [W-1:0]         result,
  output logic [$clog2(N)-1:0] winner_idx,
  output logic                 valid,
  output logic                 timeout,
  output logic [IW-1:0]        iter_count
);

  localparam int unsigned XW = $clog2(N);
  localparam int unsigned SW = W + XW;  // sum of N W-bit values never overflows
  localparam int unsigned CW = 16;      // internal iteration counter width

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [W-1:0]    a     [N];
  logic [W-1:0]    a_nxt [N];
  logic [W-1:0]    orig     [N];
  logic [W-1:0]    orig_nxt [N];
  logic [CW-1:0]   cnt, cnt_nxt;

  logic            busy_nxt, done_nxt, valid_nxt, timeout_nxt;
  logic [W-1:0]    result_nxt;
  logic [XW-1:0]   winner_idx_nxt;
  logic [IW-1:0]   iter_count_nxt;

  logic [SW-1:0]   sum;
  logic [SW-1:0]   inh   [N];
  logic [W-1:0]    a_upd [N];
  logic [XW:0]     nz;
  logic [XW-1:0]   win;

  // Datapath: total activation, per-channel inhibition, clamped update,
  // non-zero count and index of the (last) non-zero channel.
  always_comb begin
    sum = '0;
    nz  = '0;
    win = '0;
    for (int i = 0; i < int'(N); i++) begin
      sum = sum + SW'(a[i]);
      if (a[i] != '0) begin
        nz  = nz + 1'b1;
        win = XW'(i);
      end
    end
    for (int i = 0; i < int'(N); i++) begin
      inh[i]   = (sum - SW'(a[i])) >> EPS_SHIFT;
      // ReLU clamp: a channel inhibited by at least its own value dies.
      a_upd[i] = (SW'(a[i]) > inh[i]) ? (a[i] - W'(inh[i])) : '0;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_nxt      = state;
    a_nxt          = a;
    orig_nxt       = orig;
    cnt_nxt        = cnt;
    busy_nxt       = busy;
    done_nxt       = 1'b0;
    valid_nxt      = valid;
    timeout_nxt    = timeout;
    result_nxt     = result;
    winner_idx_nxt = winner_idx;
    iter_count_nxt = iter_count;

    case (state)
      S_IDLE: begin
        busy_nxt = 1'b0;
        if (start) begin
          for (int i = 0; i < int'(N); i++) begin
            a_nxt[i]    = in_data[i*W +: W];
            orig_nxt[i] = in_data[i*W +: W];
          end
          cnt_nxt   = '0;
          busy_nxt  = 1'b1;
          state_nxt = S_ITER;
        end
      end

      S_ITER: begin
        if (nz == (XW+1)'(1)) begin
          state_nxt      = S_DONE;
          done_nxt       = 1'b1;
          valid_nxt      = 1'b1;
          timeout_nxt    = 1'b0;
          winner_idx_nxt = win;
          result_nxt     = orig[win];
          iter_count_nxt = IW'(cnt);
        end else if (nz == '0) begin
          state_nxt      = S_DONE;
          done_nxt       = 1'b1;
          valid_nxt      = 1'b0;
          timeout_nxt    = 1'b0;
          winner_idx_nxt = '0;
          result_nxt     = '0;
          iter_count_nxt = IW'(cnt);
        end else if (cnt == CW'(MAX_ITER)) begin
          state_nxt      = S_DONE;
          done_nxt       = 1'b1;
          valid_nxt      = 1'b0;
          timeout_nxt    = 1'b1;
          winner_idx_nxt = '0;
          result_nxt     = '0;
          iter_count_nxt = IW'(cnt);
        end else begin
          a_nxt   = a_upd;
          cnt_nxt = cnt + 1'b1;
        end
      end

      S_DONE: begin
        state_nxt = S_IDLE;
        busy_nxt  = 1'b0;
      end

      default: begin
        state_nxt = S_IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      for (int i = 0; i < int'(N); i++) begin
        a[i]    <= '0;
        orig[i] <= '0;
      end
      cnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      valid      <= 1'b0;
      timeout    <= 1'b0;
      result     <= '0;
      winner_idx <= '0;
      iter_count <= '0;
    end else begin
      state      <= state_nxt;
      a          <= a_nxt;
      orig       <= orig_nxt;
      cnt        <= cnt_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      valid      <= valid_nxt;
      timeout    <= timeout_nxt;
      result     <= result_nxt;
      winner_idx <= winner_idx_nxt;
      iter_count <= iter_count_nxt;
    end
  end

endmodule

// File: tb/tb_maxnet_param.sv
// Testbench for maxnet_param: directed scenarios plus randomized runs,
// each compared against an arithmetic winner-take-all reference model.
module tb_maxnet_param;

  localparam int unsigned N    = 4;
  localparam int unsigned W    = 32;
  localparam int unsigned EPS  = 3;
  localparam int unsigned MAXI = 255;
  localparam int unsigned IW   = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic [N*W-1:0]       in_data;
  logic                 busy;
  logic                 done;
  logic [W-1:0]         result;
  logic [$clog2(N)-1:0] winner_idx;
  logic                 valid;
  logic                 timeout;
  logic [IW-1:0]        iter_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  maxnet_param #(
    .N(N), .W(W), .EPS_SHIFT(EPS), .MAX_ITER(MAXI), .IW(IW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data),
    .busy(busy), .done(done), .result(result), .winner_idx(winner_idx),
    .valid(valid), .timeout(timeout), .iter_count(iter_count)
  );

  task automatic check_val(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: iterate the inhibition rule on signed 64-bit integers.
  function automatic void model(input logic [N*W-1:0] din, output bit v,
                                output bit to, output int idx,
                                output longint res, output int iters);
    longint act [N];
    longint org [N];
    longint nxt [N];
    longint s, d;
    int nzc, last;
    for (int i = 0; i < int'(N); i++) begin
      act[i] = longint'(din[i*W +: W]);
      org[i] = act[i];
    end
    iters = 0;
    forever begin
      nzc = 0; last = 0; s = 0;
      for (int i = 0; i < int'(N); i++) begin
        s += act[i];
        if (act[i] != 0) begin nzc++; last = i; end
      end
      if (nzc == 1) begin
        v = 1; to = 0; idx = last; res = org[last]; return;
      end
      if (nzc == 0) begin
        v = 0; to = 0; idx = 0; res = 0; return;
      end
      if (iters == int'(MAXI)) begin
        v = 0; to = 1; idx = 0; res = 0; return;
      end
      for (int i = 0; i < int'(N); i++) begin
        d = act[i] - ((s - act[i]) >>> EPS);
        nxt[i] = (d > 0) ? d : 0;
      end
      act = nxt;
      iters++;
    end
  endfunction

  function automatic logic [N*W-1:0] pack4(input longint c0, input longint c1,
                                           input longint c2, input longint c3);
    logic [N*W-1:0] r;
    r = {W'(c3), W'(c2), W'(c1), W'(c0)};
    return r;
  endfunction

  function automatic logic [N*W-1:0] rand_din();
    logic [N*W-1:0] r;
    for (int i = 0; i < int'(N); i++) begin
      case ($urandom_range(0, 3))
        0:       r[i*W +: W] = '0;
        1:       r[i*W +: W] = W'($urandom_range(1, 300));
        2:       r[i*W +: W] = W'($urandom_range(1, 100000));
        default: r[i*W +: W] = W'($urandom);
      endcase
    end
    return r;
  endfunction

  // Called at #1 after edge start_edges; waits for done and checks results.
  task automatic wait_check(input string tag, input logic [N*W-1:0] din,
                            input int start_edges);
    bit v, to, seen;
    int idx, iters, edges;
    longint res;
    model(din, v, to, idx, res, iters);
    edges = start_edges;
    seen  = 0;
    for (int c = 0; c < int'(MAXI) + 8 && !seen; c++) begin
      @(posedge clk); #1;
      edges++;
      if (done) seen = 1;
    end
    check_val({tag, "_done_seen"}, longint'(seen), 1);
    if (seen) begin
      check_val({tag, "_latency"}, edges, iters + 1);
      check_val({tag, "_busy_in_done"}, longint'(busy), 1);
      check_val({tag, "_valid"}, longint'(valid), longint'(v));
      check_val({tag, "_timeout"}, longint'(timeout), longint'(to));
      check_val({tag, "_winner_idx"}, longint'(winner_idx), idx);
      check_val({tag, "_result"}, longint'(result), res);
      check_val({tag, "_iter_count"}, longint'(iter_count), iters);
      @(posedge clk); #1;
      check_val({tag, "_done_pulse"}, longint'(done), 0);
      check_val({tag, "_busy_off"}, longint'(busy), 0);
    end
  endtask

  task automatic run_case(input string tag, input logic [N*W-1:0] din,
                          input bit scramble);
    @(negedge clk);
    start   = 1'b1;
    in_data = din;
    @(posedge clk); #1;
    start = 1'b0;
    check_val({tag, "_busy_on"}, longint'(busy), 1);
    if (scramble) in_data = rand_din();
    wait_check(tag, din, 0);
  endtask

  task automatic check_cleared(input string tag);
    check_val({tag, "_busy"}, longint'(busy), 0);
    check_val({tag, "_done"}, longint'(done), 0);
    check_val({tag, "_valid"}, longint'(valid), 0);
    check_val({tag, "_timeout"}, longint'(timeout), 0);
    check_val({tag, "_result"}, longint'(result), 0);
    check_val({tag, "_winner_idx"}, longint'(winner_idx), 0);
    check_val({tag, "_iter_count"}, longint'(iter_count), 0);
  endtask

  initial begin
    logic [N*W-1:0] d1, d2;
    bit v1, to1, saw_done;
    int idx1, it1;
    longint res1;

    rst = 1'b1; start = 1'b0; in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check_cleared("reset");
    @(negedge clk); rst = 1'b0;

    d1 = pack4(100, 40, 20, 10);
    run_case("basic", d1, 1'b1);
    run_case("single", pack4(0, 0, 55, 0), 1'b1);
    run_case("zeros", pack4(0, 0, 0, 0), 1'b0);
    run_case("stall", pack4(8, 8, 8, 8), 1'b0);

    // Reset asserted mid-run (sampled at edge 3) aborts it silently.
    @(negedge clk); start = 1'b1; in_data = d1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check_cleared("midreset");
    rst = 1'b0;
    saw_done = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (done || busy) saw_done = 1;
    end
    check_val("midreset_quiet", longint'(saw_done), 0);
    run_case("after_reset", pack4(5, 9, 0, 0), 1'b0);

    // start pulses during ITER and DONE are ignored.
    d2 = pack4(10, 200, 30, 40);
    model(d1, v1, to1, idx1, res1, it1);
    @(negedge clk); start = 1'b1; in_data = d1;
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk); start = 1'b1; in_data = d2;
    @(posedge clk); #1; start = 1'b0;
    in_data = '0;
    wait_check("ign_iter", d1, 1);
    // Back in IDLE after wait_check; rerun and poke start while in DONE.
    @(negedge clk); start = 1'b1; in_data = d1;
    @(posedge clk); #1; start = 1'b0;
    saw_done = 0;
    for (int c = 0; c < int'(MAXI) + 8 && !saw_done; c++) begin
      @(posedge clk); #1;
      if (done) saw_done = 1;
    end
    check_val("ign_done_seen", longint'(saw_done), 1);
    start = 1'b1; in_data = d2;
    @(posedge clk); #1;
    check_val("ign_done_busy", longint'(busy), 0);
    check_val("ign_done_result", longint'(result), res1);
    check_val("ign_done_idx", longint'(winner_idx), idx1);
    check_val("ign_done_iters", longint'(iter_count), it1);
    @(posedge clk); #1;
    start = 1'b0;
    check_val("next_idle_accept", longint'(busy), 1);
    in_data = rand_din();
    wait_check("next_run", d2, 0);

    for (int t = 0; t < 30; t++) begin
      run_case($sformatf("rand%0d", t), rand_din(), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
